// File: rtl/fifo_uart_tx.sv
// Serializes FIFO head words onto an idle-high async serial line: start, WL data bits LSB first, stop.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for EN with a non-empty FIFO
// START  | start bit (line low), POP high in its first cycle
// DATA   | WL data bits, LSB first
// PARITY | even parity of the captured word (FIFO_UART_TX_PARITY_EN only)
// STOP   | stop bit (line high), DONE on its last cycle
module fifo_uart_tx #(
    parameter int WL           = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int C_WL         = $clog2(CLKS_PER_BIT),
    parameter int B_WL         = $clog2(WL)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          EMPTY,
    input  logic [WL-1:0] head,
    output logic          POP,
    output logic          TX,
    output logic          BUSY,
    output logic          DONE
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_n;
    logic [C_WL-1:0] timer, timer_n;
    logic [B_WL-1:0] idx, idx_n;
    logic [WL-1:0]   shift, shift_n;
    logic            bit_end;
    logic            tx_n, pop_n, busy_n, done_n;
`ifdef FIFO_UART_TX_PARITY_EN
    logic            par, par_n;
`endif

    assign bit_end = (timer == C_WL'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            shift <= '0;
            TX    <= 1'b1;
            POP   <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            timer <= timer_n;
            idx   <= idx_n;
            shift <= shift_n;
            TX    <= tx_n;
            POP   <= pop_n;
            BUSY  <= busy_n;
            DONE  <= done_n;
`ifdef FIFO_UART_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        shift_n = shift;
`ifdef FIFO_UART_TX_PARITY_EN
        par_n   = par;
`endif
        if (state != IDLE) begin
            timer_n = bit_end ? '0 : timer + C_WL'(1);
        end

        case (state)
            IDLE: begin
                if (EN && !EMPTY) begin
                    shift_n = head;
`ifdef FIFO_UART_TX_PARITY_EN
                    par_n   = ^head;
`endif
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (idx == B_WL'(WL - 1)) begin
                        idx_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + B_WL'(1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START: tx_n = 1'b0;
            DATA:  tx_n = shift_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: tx_n = par;
`endif
            default: tx_n = 1'b1;
        endcase
        pop_n  = (state == IDLE) && (state_n == START);
        busy_n = (state_n != IDLE);
        done_n = (state_n == STOP) && (timer_n == C_WL'(CLKS_PER_BIT - 1));
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: FIFO model feeds words, a scoreboard holds expected frames.
// Honours FIFO_UART_TX_PARITY_EN when computing the expected frame.
module tb_fifo_uart_tx;
    localparam int WL  = 4;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB  = WL + 3;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = WL + 2;
    localparam bit PAR = 1'b0;
`endif
    localparam int FL  = NB * CPB;

    logic          CLK = 1'b0;
    logic          RST;
    logic          EN;
    logic          EMPTY;
    logic [WL-1:0] head;
    logic          POP, TX, BUSY, DONE;

    int n_cmp = 0;
    int n_err = 0;
    int underflow = 0;
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [WL-1:0] mem [16];
    logic [WL-1:0] exp_q [$];

    fifo_uart_tx #(.WL(WL), .CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .EMPTY(EMPTY), .head(head),
        .POP(POP), .TX(TX), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    assign EMPTY = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[3:0]];

    always @(negedge CLK) begin
        if (POP === 1'b1) begin
            if (wr_ptr == rd_ptr) underflow <= underflow + 1;
            else rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [WL-1:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    // Returns at the negedge inside the first START cycle; t = negedges waited.
    task automatic wait_start(input string tag, output int t);
        t = 0;
        while (TX !== 1'b0 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        check({tag, "_start"}, TX, 1'b0);
    endtask

    task automatic capture_frame(input string tag, input int drop_at);
        logic [FL-1:0] o_tx, o_pop, o_busy, o_done, e_tx;
        logic [WL-1:0] w;
        int b;
        w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        for (int c = 0; c < FL; c++) begin
            b = c / CPB;
            if (b == 0)                    e_tx[c] = 1'b0;
            else if (b <= WL)              e_tx[c] = w[b-1];
            else if (PAR && b == WL + 1)   e_tx[c] = ^w;
            else                           e_tx[c] = 1'b1;
        end
        for (int c = 0; c < FL; c++) begin
            if (c == drop_at) EN = 1'b0;
            o_tx[c]   = TX;
            o_pop[c]  = POP;
            o_busy[c] = BUSY;
            o_done[c] = DONE;
            @(negedge CLK);
        end
        check({tag, "_tx"},   o_tx, e_tx);
        check({tag, "_pop"},  o_pop, FL'(1));
        check({tag, "_busy"}, o_busy, {FL{1'b1}});
        check({tag, "_done"}, o_done, FL'(1) << (FL - 1));
        check({tag, "_idle"}, {TX, BUSY, POP, DONE}, 4'b1000);
    endtask

    initial begin
        int t;
        int bad;
        RST = 1'b1;
        EN  = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_vals", {TX, BUSY, POP, DONE}, 4'b1000);
        RST = 1'b0;
        EN  = 1'b1;

        // Empty FIFO: nothing should move.
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("empty_idle", {TX, BUSY, POP, DONE}, 4'b1000);
        end

        // Single word.
        push_word(4'd3);
        wait_start("w3", t);
        check("w3_latency", t, 1);
        capture_frame("w3", -1);

        // Back-to-back 4 then 7, FIFO never empty in between.
        push_word(4'd4);
        push_word(4'd7);
        wait_start("w4", t);
        check("w4_gap", t, 1);
        capture_frame("w4", -1);
        wait_start("w7", t);
        check("w7_gap", t, 1);
        capture_frame("w7", -1);

        // EN dropped during DATA of word 6 with word 9 still queued.
        push_word(4'd6);
        push_word(4'd9);
        wait_start("w6", t);
        capture_frame("w6", 2 * CPB + 1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (POP !== 1'b0 || TX !== 1'b1 || BUSY !== 1'b0) bad++;
            @(negedge CLK);
        end
        check("en_off_quiet", bad, 0);
        check("en_off_level", wr_ptr - rd_ptr, 1);
        EN = 1'b1;
        wait_start("w9", t);
        capture_frame("w9", -1);

        // Asynchronous reset in the middle of DATA; the popped word is lost.
        push_word(4'd5);
        wait_start("w5", t);
        repeat (7) @(negedge CLK);
        #2 RST = 1'b1;
        #1 check("rst_async", {TX, BUSY, POP, DONE}, 4'b1000);
        void'(exp_q.pop_front());
        @(negedge CLK);
        check("rst_level", wr_ptr - rd_ptr, 0);
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("rst_idle", {TX, BUSY, POP, DONE}, 4'b1000);
        end
        push_word(4'd10);
        wait_start("w10", t);
        check("w10_latency", t, 1);
        capture_frame("w10", -1);

        check("underflow", underflow, 0);
        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream consumer for the FIFO block. It drains words from the FIFO's first-word-fall-through `head` output and serializes each one onto a single asynchronous serial line. Each frame is a start bit, WL data bits LSB first, and a stop bit. It is the transmit end of the FIFO datapath: the FIFO buffers bursts and this block paces them out at a fixed bit rate.

## Interface
- `WL`, 4, data word length in bits; must match the FIFO's `WL`.
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; must be ≥ 2.
- `C_WL`, `$clog2(CLKS_PER_BIT)`, bit-timer counter width.
- `B_WL`, `$clog2(WL)`, data-bit index width.

Ports:
- `CLK`  in  1  single system clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `EN`  in  1  permits starting new frames.
- `EMPTY`  in  1  FIFO empty flag.
- `head`  in  WL  FIFO front word; valid whenever `EMPTY`=0.
- `POP`  out  1  one-cycle pop request to the FIFO.
- `TX`  out  1  serial line; idle-high.
- `BUSY`  out  1  high while a frame is in progress.
- `DONE`  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE:
  - `TX`=1, `BUSY`=0.
  - If `EN`=1 and `EMPTY`=0 at a rising edge: capture `head` into the shift register, set `POP`=1 for the following cycle only, and go to START.
- START: `TX`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - `TX`=shift[0]; each bit is held for CLKS_PER_BIT cycles.
  - Shift right after each bit.
  - After bit WL-1, go to PARITY if compiled in, else STOP.
- STOP:
  - `TX`=1 for CLKS_PER_BIT cycles.
  - `DONE`=1 on the final cycle.
  - Then go to IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. The bit index wraps only on the DATA exit.
- `BUSY`=1 in every state except IDLE.
- `EN` falling mid-frame: the current frame completes; no new frame starts.
- `EMPTY` and `head` are sampled only in IDLE. Changes during a frame have no effect.
- `POP` is never asserted when `EMPTY`=1 was sampled, so underflow cannot occur.
- `RST` asserted mid-frame, immediately and asynchronously:
  - state=IDLE, `TX`=1, `POP`=0, `BUSY`=0, `DONE`=0, counters cleared.
  - The word already popped is discarded; it is not re-sent.

## Timing
- Reset values: `TX`=1, `POP`=0, `BUSY`=0, `DONE`=0, state=IDLE, timer=0, bit index=0, shift register=0.
- All outputs are registered.
- Capture edge to `TX` falling: same edge. `TX` is low starting the cycle after capture.
- `POP` is high exactly in the first cycle of START. The FIFO removes the word at the end of that cycle.
- Frame length is (2+WL)·CLKS_PER_BIT cycles, or (3+WL)·CLKS_PER_BIT with parity.
- Back-to-back frames have exactly one IDLE cycle (`TX`=1) between a STOP's last cycle and the next START.
- Sustained throughput is one word per frame length + 1 cycles.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the captured word) for CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic; the frame is start + WL data + stop.

## Test plan
- Reset, then hold `EMPTY`=1 for 20 cycles → `TX`=1, `POP`=0, `BUSY`=0 throughout.
- Single word, WL=4, CLKS_PER_BIT=4, `head`=3, `EMPTY`=0 for one capture, no parity:
  - `POP` pulses for 1 cycle.
  - `TX` sequence per 4-cycle bit is 0,1,1,0,0,1.
  - `DONE` pulses at cycle 24.
  - `BUSY` is high 24 cycles.
- Back-to-back words 4 then 7, with `EMPTY` staying 0:
  - Data bits are 0,0,1,0 then 1,1,1,0.
  - Exactly one idle-high cycle separates the frames.
  - Exactly two `POP` pulses.
- Parity build, words 3 and 7 → parity bit 0 for 3 and 1 for 7; frame length 28 cycles each.
- `EN` dropped during DATA of word 6 with the FIFO still non-empty → word 6 completes, then `TX` stays 1 and no further `POP`.
- `RST` asserted mid-DATA → `TX`=1 and `BUSY`=0 without waiting for a clock edge. After release, the next word starts a fresh frame with a correct start bit.
